riscv_hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding controller for the pipelined RISC-V core; successor to the combinational forwarding block.

---
 rtl/riscv_hazard_scoreboard.sv | 225 ++++++++++++++++++++++
 tb/tb_riscv_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// riscv_hazard_scoreboard
//
// Hazard and forwarding controller for the pipelined RISC-V core. It keeps a
// private copy of the register-usage fields of every instruction from Execute
// to Writeback. From that copy it derives:
//   - the forwarding selects for the Execute operands,
//   - the Decode write-through selects,
//   - load-use / RAW stalls,
//   - branch flushes,
//   - a memory-wait freeze.
// It also counts the cycles in which the PC was held.
//
// Parameters
//   DEPTH   tracked stages after Decode (slot0=E, slot1=M, slot DEPTH-1=W), 3..6
//   FWD_EN  1: forward from M/W into E; 0: no E forwarding, stall on every RAW
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports
//   clock, reset                  core clock, asynchronous active-low reset
//   issue_d                       Decode holds a valid instruction
//   rs1_d, rs2_d                  Decode source registers
//   rs1_used_d, rs2_used_d        the source register is actually read
//   rd_d, regwrite_d, load_d      Decode destination, writes-rd, is-a-load
//   branch_taken_e                Execute redirects the PC this cycle
//   mem_busy                      data memory not ready; the whole pipe freezes
//   stall_f, stall_d              hold PC / hold F/D register
//   flush_d, flush_e              clear F/D register / clear D/E register (bubble)
//   freeze                        hold E/M and M/W registers
//   fwd_a_e, fwd_b_e              E operand select: 00 regfile, 10 from M, 01 from W
//   fwd_a_d, fwd_b_d              Decode write-through from W
//   stall_cnt                     cycles with stall_f=1, saturating at all-ones
//
// Control contract with the stage modules: there is no valid/ready handshake.
// Every control output is a same-cycle command. A stage obeys it on the next
// clock edge, and the scoreboard advances on that same edge exactly as the
// pipeline does.
// Priority: mem_busy > branch_taken_e > RAW hazard.
// ---------------------------------------------------------------------------
module riscv_hazard_scoreboard #(
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_d,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic             rs1_used_d,
   input  logic             rs2_used_d,
   input  logic [4:0]       rd_d,
   input  logic             regwrite_d,
   input  logic             load_d,
   input  logic             branch_taken_e,
   input  logic             mem_busy,
   output logic             stall_f,
   output logic             stall_d,
   output logic             flush_d,
   output logic             flush_e,
   output logic             freeze,
   output logic [1:0]       fwd_a_e,
   output logic [1:0]       fwd_b_e,
   output logic             fwd_a_d,
   output logic             fwd_b_d,
   output logic [CNT_W-1:0] stall_cnt
);

   // One tracked instruction. The source fields are kept so that the
   // Execute-stage selects can be derived from slot0's own operands.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regWrite;
      logic       load;
      logic [4:0] rs1;
      logic       rs1Used;
      logic [4:0] rs2;
      logic       rs2Used;
   } slotT;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntMax = '1;

   slotT sb [DEPTH];

   // Goes high on the first clock edge after reset is released. Until then
   // every output is forced low, so the stages see a quiet first cycle.
   logic armed;

   logic hzRaw;
   logic memBusyG;
   logic branchG;
   logic hzG;
   logic [1:0] fwdASel;
   logic [1:0] fwdBSel;
   logic wtA;
   logic wtB;
   slotT decodeSlot;

   // A slot produces a value that the consumer needs.
   // x0 is never a real producer.
   function automatic logic slotMatch(input slotT s, input logic [4:0] src,
                                      input logic used);
      return s.valid && s.regWrite && (s.rd != 5'd0) && (s.rd == src) && used;
   endfunction

   // Execute operand select. A load in M has no data yet, so it cannot
   // forward. The load-use stall already guarantees that such a consumer
   // only reaches E once the load sits in W.
   function automatic logic [1:0] eSelect(input slotT mSlot, input slotT wSlot,
                                          input logic [4:0] src, input logic used);
      logic [1:0] sel;
      sel = 2'b00;
      if (slotMatch(mSlot, src, used) && !mSlot.load) begin
         sel = 2'b10;
      end else if (slotMatch(wSlot, src, used)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // RAW hazard detection on the instruction in Decode.
   always_comb begin
      hzRaw = 1'b0;
      if (FWD_EN != 0) begin
         // A load in E cannot forward in time.
         if (sb[0].load && (slotMatch(sb[0], rs1_d, rs1_used_d) ||
                            slotMatch(sb[0], rs2_d, rs2_used_d))) begin
            hzRaw = 1'b1;
         end
         // Slots between M and W have no forward path. The loop is empty
         // for DEPTH=3.
         for (int k = 2; k <= DEPTH - 2; k++) begin
            if (slotMatch(sb[k], rs1_d, rs1_used_d) ||
                slotMatch(sb[k], rs2_d, rs2_used_d)) begin
               hzRaw = 1'b1;
            end
         end
      end else begin
         // Without forwarding, only the W write-through can serve Decode.
         for (int k = 0; k <= DEPTH - 2; k++) begin
            if (slotMatch(sb[k], rs1_d, rs1_used_d) ||
                slotMatch(sb[k], rs2_d, rs2_used_d)) begin
               hzRaw = 1'b1;
            end
         end
      end
   end

   // Selects and priority resolution.
   always_comb begin
      fwdASel = 2'b00;
      fwdBSel = 2'b00;
      if (FWD_EN != 0) begin
         fwdASel = eSelect(sb[1], sb[DEPTH-1], sb[0].rs1, sb[0].rs1Used);
         fwdBSel = eSelect(sb[1], sb[DEPTH-1], sb[0].rs2, sb[0].rs2Used);
      end
      wtA = slotMatch(sb[DEPTH-1], rs1_d, rs1_used_d);
      wtB = slotMatch(sb[DEPTH-1], rs2_d, rs2_used_d);

      // A branch seen during a freeze is dropped; Execute re-asserts it once
      // the freeze lifts.
      memBusyG = armed && mem_busy;
      branchG  = armed && !mem_busy && branch_taken_e;
      hzG      = armed && !mem_busy && !branch_taken_e && hzRaw;
   end

   // Control outputs.
   always_comb begin
      freeze  = memBusyG;
      stall_f = memBusyG || hzG;
      stall_d = memBusyG || hzG;
      flush_d = branchG;
      flush_e = branchG || hzG;
      fwd_a_e = armed ? fwdASel : 2'b00;
      fwd_b_e = armed ? fwdBSel : 2'b00;
      fwd_a_d = armed && wtA;
      fwd_b_d = armed && wtB;
   end

   // Decode fields as they enter slot0. A non-issuing Decode enters as an
   // all-zero bubble, so its stale source fields never drive a select.
   always_comb begin
      decodeSlot = '0;
      if (issue_d) begin
         decodeSlot.valid    = 1'b1;
         decodeSlot.rd       = rd_d;
         decodeSlot.regWrite = regwrite_d;
         decodeSlot.load     = load_d;
         decodeSlot.rs1      = rs1_d;
         decodeSlot.rs1Used  = rs1_used_d;
         decodeSlot.rs2      = rs2_d;
         decodeSlot.rs2Used  = rs2_used_d;
      end
   end

   // Scoreboard shift and the stall counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         armed     <= 1'b0;
         stall_cnt <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            sb[k] <= '0;
         end
      end else begin
         armed <= 1'b1;
         if (!memBusyG) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
               sb[k] <= sb[k-1];
            end
            // A flush or a RAW stall places a bubble in E.
            if (branchG || hzG) begin
               sb[0] <= '0;
            end else begin
               sb[0] <= decodeSlot;
            end
         end
         if (stall_f && (stall_cnt != CntMax)) begin
            stall_cnt <= stall_cnt + CntOne;
         end
      end
   end

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// Testbench for riscv_hazard_scoreboard. Three instances share one stimulus
// stream:
//   u0  DEPTH=3, FWD_EN=1, CNT_W=32
//   u1  DEPTH=4, FWD_EN=0, CNT_W=32
//   u2  DEPTH=3, FWD_EN=1, CNT_W=4
// Each directed step pushes a hand-computed expectation, tagged with its cycle
// and target instance, into a queue. A monitor on the falling edge pops and
// compares every entry whose cycle has come.
// ---------------------------------------------------------------------------
module tb_riscv_hazard_scoreboard;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic       issueD;
   logic [4:0] rs1D;
   logic [4:0] rs2D;
   logic       rs1UsedD;
   logic       rs2UsedD;
   logic [4:0] rdD;
   logic       regWriteD;
   logic       loadD;
   logic       branchE;
   logic       memBusy;

   logic       sfW [3];
   logic       sdW [3];
   logic       fdW [3];
   logic       feW [3];
   logic       fzW [3];
   logic [1:0] faW [3];
   logic [1:0] fbW [3];
   logic       adW [3];
   logic       bdW [3];
   logic [31:0] cnt0;
   logic [31:0] cnt1;
   logic [3:0]  cnt2;

   riscv_hazard_scoreboard #(.DEPTH(3), .FWD_EN(1), .CNT_W(32)) u0 (
      .clock(clock), .reset(reset), .issue_d(issueD), .rs1_d(rs1D), .rs2_d(rs2D),
      .rs1_used_d(rs1UsedD), .rs2_used_d(rs2UsedD), .rd_d(rdD),
      .regwrite_d(regWriteD), .load_d(loadD), .branch_taken_e(branchE),
      .mem_busy(memBusy), .stall_f(sfW[0]), .stall_d(sdW[0]), .flush_d(fdW[0]),
      .flush_e(feW[0]), .freeze(fzW[0]), .fwd_a_e(faW[0]), .fwd_b_e(fbW[0]),
      .fwd_a_d(adW[0]), .fwd_b_d(bdW[0]), .stall_cnt(cnt0));

   riscv_hazard_scoreboard #(.DEPTH(4), .FWD_EN(0), .CNT_W(32)) u1 (
      .clock(clock), .reset(reset), .issue_d(issueD), .rs1_d(rs1D), .rs2_d(rs2D),
      .rs1_used_d(rs1UsedD), .rs2_used_d(rs2UsedD), .rd_d(rdD),
      .regwrite_d(regWriteD), .load_d(loadD), .branch_taken_e(branchE),
      .mem_busy(memBusy), .stall_f(sfW[1]), .stall_d(sdW[1]), .flush_d(fdW[1]),
      .flush_e(feW[1]), .freeze(fzW[1]), .fwd_a_e(faW[1]), .fwd_b_e(fbW[1]),
      .fwd_a_d(adW[1]), .fwd_b_d(bdW[1]), .stall_cnt(cnt1));

   riscv_hazard_scoreboard #(.DEPTH(3), .FWD_EN(1), .CNT_W(4)) u2 (
      .clock(clock), .reset(reset), .issue_d(issueD), .rs1_d(rs1D), .rs2_d(rs2D),
      .rs1_used_d(rs1UsedD), .rs2_used_d(rs2UsedD), .rd_d(rdD),
      .regwrite_d(regWriteD), .load_d(loadD), .branch_taken_e(branchE),
      .mem_busy(memBusy), .stall_f(sfW[2]), .stall_d(sdW[2]), .flush_d(fdW[2]),
      .flush_e(feW[2]), .freeze(fzW[2]), .fwd_a_e(faW[2]), .fwd_b_e(fbW[2]),
      .fwd_a_d(adW[2]), .fwd_b_d(bdW[2]), .stall_cnt(cnt2));

   // ---------------- cycle stamp ----------------
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   // ctl layout: {stall_f, stall_d, flush_d, flush_e, freeze,
   //              fwd_a_e[1:0], fwd_b_e[1:0], fwd_a_d, fwd_b_d}
   typedef struct packed {
      int          cyc;
      logic [1:0]  dut;
      logic [10:0] ctl;
      logic [31:0] cnt;
      logic        chkCnt;
   } expT;

   expT   expQ [$];
   string nameQ [$];
   int    nChecks = 0;
   int    nPass   = 0;

   function automatic logic [10:0] mk(input logic sf, input logic sd, input logic fd,
                                      input logic fe, input logic fz,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic ad, input logic bd);
      return {sf, sd, fd, fe, fz, fa, fb, ad, bd};
   endfunction

   function automatic logic [31:0] cntOf(input logic [1:0] d);
      case (d)
         2'd0:    return cnt0;
         2'd1:    return cnt1;
         default: return {28'd0, cnt2};
      endcase
   endfunction

   task automatic ex(input logic [1:0] d, input string nm, input logic [10:0] ctl,
                     input logic [31:0] cnt, input logic chkCnt);
      expT e;
      e.cyc = cyc; e.dut = d; e.ctl = ctl; e.cnt = cnt; e.chkCnt = chkCnt;
      expQ.push_back(e);
      nameQ.push_back(nm);
   endtask

   expT         monE;
   string       monName;
   logic [10:0] actCtl;
   logic [31:0] actCnt;

   always @(negedge clock) begin
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
         monE    = expQ.pop_front();
         monName = nameQ.pop_front();
         actCtl  = {sfW[monE.dut], sdW[monE.dut], fdW[monE.dut], feW[monE.dut],
                    fzW[monE.dut], faW[monE.dut], fbW[monE.dut], adW[monE.dut],
                    bdW[monE.dut]};
         actCnt  = cntOf(monE.dut);
         nChecks++;
         if (actCtl !== monE.ctl || (monE.chkCnt && actCnt !== monE.cnt)) begin
            $display("FAIL %s (u%0d): got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                     monName, monE.dut, actCtl, actCnt, monE.ctl, monE.cnt);
         end else begin
            nPass++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drv(input logic iss, input logic [4:0] rd, input logic rw,
                      input logic ld, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic br,
                      input logic mb);
      issueD = iss; rdD = rd; regWriteD = rw; loadD = ld;
      rs1D = rs1; rs1UsedD = u1; rs2D = rs2; rs2UsedD = u2;
      branchE = br; memBusy = mb;
   endtask

   task automatic nop(input logic mb);
      drv(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, mb);
   endtask

   // Reset, then one post-release cycle with branch and mem_busy raised: all
   // outputs must stay quiet in that cycle.
   task automatic doReset();
      reset = 1'b0;
      nop(1'b0);
      tick();
      tick();
      reset = 1'b1;
      drv(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      for (int d = 0; d < 3; d++) ex(d[1:0], "post-reset quiet", 11'd0, 32'd0, 1'b1);
      tick();
   endtask

   localparam logic [10:0] Quiet = 11'd0;

   // ---------------- directed tests ----------------
   initial begin
      logic [10:0] hzCtl;
      logic [10:0] fzCtl;
      hzCtl = mk(1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0);
      nop(1'b0);

      // T1: add x5 ; sub x6,x5 ; or x9,x4,x5 ; xor x10,x5
      doReset();
      drv(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 0, 0);  ex(0, "t1 add issue", Quiet, 0, 1); tick();
      drv(1, 5'd6, 1, 0, 5'd5, 1, 5'd3, 1, 0, 0);  ex(0, "t1 sub in D", Quiet, 0, 1); tick();
      drv(1, 5'd9, 1, 0, 5'd4, 1, 5'd5, 1, 0, 0);
      ex(0, "t1 fwd from M", mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0), 0, 1); tick();
      drv(1, 5'd10, 1, 0, 5'd5, 1, 5'd0, 0, 0, 0);
      ex(0, "t1 fwd from W + write-through", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0), 0, 1); tick();
      nop(1'b0); ex(0, "t1 drained", Quiet, 0, 1); tick();

      // T2: lw x7 ; add x8,x7,x1 (load-use) ; then lw x0 / add x11,x0,x0
      doReset();
      drv(1, 5'd7, 1, 1, 5'd1, 1, 5'd0, 0, 0, 0);  ex(0, "t2 lw issue", Quiet, 0, 1); tick();
      drv(1, 5'd8, 1, 0, 5'd7, 1, 5'd1, 1, 0, 0);  ex(0, "t2 load-use stall", hzCtl, 0, 1); tick();
      drv(1, 5'd8, 1, 0, 5'd7, 1, 5'd1, 1, 0, 0);  ex(0, "t2 after bubble", Quiet, 1, 1); tick();
      nop(1'b0); ex(0, "t2 fwd W after load", mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0), 1, 1); tick();
      drv(1, 5'd0, 1, 1, 5'd1, 1, 5'd0, 0, 0, 0);  ex(0, "t2 lw x0 issue", Quiet, 1, 1); tick();
      drv(1, 5'd11, 1, 0, 5'd0, 1, 5'd0, 1, 0, 0); ex(0, "t2 x0 no stall", Quiet, 1, 1); tick();
      nop(1'b0); ex(0, "t2 x0 no fwd", Quiet, 1, 1); tick();

      // T3: branch taken while a load-use hazard sits in Decode
      doReset();
      drv(1, 5'd7, 1, 1, 5'd1, 1, 5'd0, 0, 0, 0);  ex(0, "t3 lw issue", Quiet, 0, 1); tick();
      drv(1, 5'd8, 1, 0, 5'd7, 1, 5'd1, 1, 1, 0);
      ex(0, "t3 branch beats load-use", mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0), 0, 1); tick();
      nop(1'b0); ex(0, "t3 after flush", Quiet, 0, 1); tick();

      // T4: mem_busy for 3 cycles with an M forward pending
      doReset();
      fzCtl = mk(1, 1, 0, 0, 1, 2'b10, 2'b00, 0, 0);
      drv(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 0, 0); tick();
      drv(1, 5'd6, 1, 0, 5'd5, 1, 5'd3, 1, 0, 0); tick();
      drv(1, 5'd9, 1, 0, 5'd4, 1, 5'd5, 1, 0, 1); ex(0, "t4 freeze 1", fzCtl, 0, 1); tick();
      drv(1, 5'd9, 1, 0, 5'd4, 1, 5'd5, 1, 1, 1); ex(0, "t4 freeze 2 branch ignored", fzCtl, 1, 1); tick();
      drv(1, 5'd9, 1, 0, 5'd4, 1, 5'd5, 1, 0, 1); ex(0, "t4 freeze 3", fzCtl, 2, 1); tick();
      drv(1, 5'd9, 1, 0, 5'd4, 1, 5'd5, 1, 0, 0);
      ex(0, "t4 resume same select", mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0), 3, 1); tick();
      nop(1'b0); ex(0, "t4 fwd W", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0), 3, 1); tick();

      // T5: FWD_EN=0, DEPTH=4: add x3 ; add x4,x3,x0
      doReset();
      drv(1, 5'd3, 1, 0, 5'd1, 1, 5'd2, 1, 0, 0); ex(1, "t5 issue", Quiet, 0, 1); tick();
      drv(1, 5'd4, 1, 0, 5'd3, 1, 5'd0, 1, 0, 0); ex(1, "t5 stall E", hzCtl, 0, 1); tick();
      drv(1, 5'd4, 1, 0, 5'd3, 1, 5'd0, 1, 0, 0); ex(1, "t5 stall M1", hzCtl, 1, 1); tick();
      drv(1, 5'd4, 1, 0, 5'd3, 1, 5'd0, 1, 0, 0); ex(1, "t5 stall M2", hzCtl, 2, 1); tick();
      drv(1, 5'd4, 1, 0, 5'd3, 1, 5'd0, 1, 0, 0);
      ex(1, "t5 write-through", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0), 3, 1); tick();
      nop(1'b0); ex(1, "t5 no E forward", Quiet, 3, 1); tick();

      // T6: counter saturation on CNT_W=4, then async reset mid-stall
      doReset();
      fzCtl = mk(1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
      for (int i = 1; i <= 17; i++) begin
         nop(1'b1);
         if (i == 15) ex(2, "t6 cnt 14", fzCtl, 14, 1);
         if (i == 16) ex(2, "t6 cnt 15", fzCtl, 15, 1);
         if (i == 17) begin
            ex(2, "t6 saturated", fzCtl, 15, 1);
            ex(0, "t6 wide counter", fzCtl, 16, 1);
         end
         tick();
      end
      nop(1'b1);
      reset = 1'b0;
      ex(2, "t6 async reset u2", Quiet, 0, 1);
      ex(0, "t6 async reset u0", Quiet, 0, 1);
      tick();
      tick();

      nChecks++;
      if (expQ.size() != 0) $display("FAIL queue drain: got %0d pending, expected 0", expQ.size());
      else nPass++;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
